// File: rtl/beam_trig_pkg.sv
// Shared helpers for the beam-power trigger.
//   pow_bits : accumulator width from sample width, samples per clock and window depth
//   beam_lsb : LSB of sample s of beam b inside the flat beam bus
//   sat_inc  : increment that sticks at the all-ones value of a given width
package beam_trig_pkg;

   localparam int SAT_W = 32;

   function automatic int pow_bits(input int beam_bits, input int nsamp, input int win);
      return 2*beam_bits - 1 + $clog2(nsamp) + $clog2(win);
   endfunction

   function automatic int beam_lsb(input int b, input int s, input int nsamp, input int beam_bits);
      return (b*nsamp + s)*beam_bits;
   endfunction

   function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val,
                                                input logic             inc,
                                                input int               bits);
      logic [SAT_W-1:0] max_v;
      max_v = (bits >= SAT_W) ? '1 : ((SAT_W'(1) << bits) - SAT_W'(1));
      return (inc && (val != max_v)) ? val + SAT_W'(1) : val;
   endfunction

endpackage

// File: rtl/beam_power_pipe.sv
// One beam: decode -> square -> sum -> sliding window -> compare/holdoff.
// Ports:
//   aclk, aresetn : clock, async active-low reset
//   samp_i        : NSAMP samples of this beam, sample s at [s*BEAM_BITS +: BEAM_BITS]
//   mask_i        : 1 = suppress triggers (pipeline keeps running)
//   thr_i         : active threshold, fires on acc > thr_i
//   trigger_o     : registered trigger pulse, three edges after the sample edge
module beam_power_pipe
   import beam_trig_pkg::*;
#(
   parameter int    NSAMP         = 8,
   parameter int    BEAM_BITS     = 8,
   parameter string OFFSET_BINARY = "FALSE",
   parameter int    WIN           = 4,
   parameter int    HOLDOFF       = 8,
   parameter int    POW_BITS      = 20
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic [NSAMP*BEAM_BITS-1:0] samp_i,
   input  logic                       mask_i,
   input  logic [POW_BITS-1:0]        thr_i,
   output logic                       trigger_o
);

   localparam int SQ_BITS  = 2*BEAM_BITS - 1;
   localparam int PROD_W   = 2*BEAM_BITS;
   localparam int SUM_BITS = SQ_BITS + $clog2(NSAMP);
   localparam int HOLD_W   = $clog2(HOLDOFF + 1);
   localparam logic [BEAM_BITS-1:0] MSB_FLIP =
      (OFFSET_BINARY == "TRUE") ? {1'b1, {(BEAM_BITS-1){1'b0}}} : '0;

   logic signed [BEAM_BITS-1:0] samp_q [NSAMP];
   logic signed [PROD_W-1:0]    prod_d [NSAMP];
   logic [SQ_BITS-1:0]          sq_d   [NSAMP];
   logic [SQ_BITS-1:0]          sq_q   [NSAMP];
   logic [SUM_BITS-1:0]         sum_d;
   logic [SUM_BITS-1:0]         win_q  [WIN];
   logic [POW_BITS-1:0]         acc_d, acc_q;
   logic [HOLD_W-1:0]           hold_q;
   logic                        fire_d, trig_q;

   always_comb begin
      sum_d = '0;
      for (int s = 0; s < NSAMP; s++) begin
         // Sign-extend before multiplying; the top bit of the product is always 0.
         prod_d[s] = PROD_W'(samp_q[s]) * PROD_W'(samp_q[s]);
         sq_d[s]   = prod_d[s][SQ_BITS-1:0];
         sum_d     = sum_d + SUM_BITS'(sq_q[s]);
      end
      // The oldest entry is part of acc, so this never underflows.
      acc_d  = acc_q + POW_BITS'(sum_d) - POW_BITS'(win_q[WIN-1]);
      fire_d = (acc_q > thr_i) && !mask_i && (hold_q == '0);
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int s = 0; s < NSAMP; s++) begin
            samp_q[s] <= '0;
            sq_q[s]   <= '0;
         end
         for (int w = 0; w < WIN; w++) win_q[w] <= '0;
         acc_q  <= '0;
         hold_q <= '0;
         trig_q <= 1'b0;
      end else begin
         for (int s = 0; s < NSAMP; s++) begin
            samp_q[s] <= samp_i[beam_lsb(0, s, NSAMP, BEAM_BITS) +: BEAM_BITS] ^ MSB_FLIP;
            sq_q[s]   <= sq_d[s];
         end
         win_q[0] <= sum_d;
         for (int w = 1; w < WIN; w++) win_q[w] <= win_q[w-1];
         acc_q  <= acc_d;
         trig_q <= fire_d;
         if (fire_d)              hold_q <= HOLD_W'(HOLDOFF);
         else if (hold_q != '0)   hold_q <= hold_q - HOLD_W'(1);
      end
   end

   assign trigger_o = trig_q;

endmodule

// File: rtl/beam_power_trigger.sv
// Beam-power trigger top: NBEAMS pipelines, double-buffered thresholds,
// per-beam saturating scalers latched every PERIOD_CLKS clocks.
// Ports:
//   aclk, aresetn                  : clock, async active-low reset
//   beam_i                         : beam b sample s at [(b*NSAMP+s)*BEAM_BITS +: BEAM_BITS]
//   beam_mask_i                    : 1 = beam masked
//   thr_wr_i/thr_addr_i/thr_dat_i  : staging threshold write
//   thr_update_i                   : copy all staging thresholds to active
//   trigger_o                      : per-beam trigger pulses
//   count_addr_i/count_o           : latched scaler readout, one clock latency
//   count_done_o                   : pulse when the latched scalers refresh
module beam_power_trigger
   import beam_trig_pkg::*;
#(
   parameter int    NBEAMS        = 48,
   parameter int    NSAMP         = 8,
   parameter int    BEAM_BITS     = 8,
   parameter string OFFSET_BINARY = "FALSE",
   parameter int    WIN           = 4,
   parameter int    HOLDOFF       = 8,
   parameter int    CNT_BITS      = 16,
   parameter int    PERIOD_CLKS   = 375000,
   localparam int   POW_BITS      = pow_bits(BEAM_BITS, NSAMP, WIN),
   localparam int   AW            = (NBEAMS > 1) ? $clog2(NBEAMS) : 1
) (
   input  logic                              aclk,
   input  logic                              aresetn,
   input  logic [NBEAMS*NSAMP*BEAM_BITS-1:0] beam_i,
   input  logic [NBEAMS-1:0]                 beam_mask_i,
   input  logic                              thr_wr_i,
   input  logic [AW-1:0]                     thr_addr_i,
   input  logic [POW_BITS-1:0]               thr_dat_i,
   input  logic                              thr_update_i,
   output logic [NBEAMS-1:0]                 trigger_o,
   input  logic [AW-1:0]                     count_addr_i,
   output logic [CNT_BITS-1:0]               count_o,
   output logic                              count_done_o
);

   localparam int          PER_W = (PERIOD_CLKS > 1) ? $clog2(PERIOD_CLKS) : 1;
   localparam logic [AW:0] NB_L  = (AW+1)'(NBEAMS);

   function automatic logic [CNT_BITS-1:0] cnt_inc(input logic [CNT_BITS-1:0] v, input logic inc);
      return CNT_BITS'(sat_inc(SAT_W'(v), inc, CNT_BITS));
   endfunction

   logic [POW_BITS-1:0] thr_stage_q [NBEAMS];
   logic [POW_BITS-1:0] thr_act_q   [NBEAMS];
   logic [NBEAMS-1:0]   trig;
   logic [CNT_BITS-1:0] run_q [NBEAMS];
   logic [CNT_BITS-1:0] lat_q [NBEAMS];
   logic [PER_W-1:0]    per_q;
   logic                per_last;
   logic [CNT_BITS-1:0] rd_run, rd_lat;
   logic                rd_trig;
   logic [CNT_BITS-1:0] count_q;
   logic                done_q;

   for (genvar b = 0; b < NBEAMS; b++) begin : g_beam
      beam_power_pipe #(
         .NSAMP         (NSAMP),
         .BEAM_BITS     (BEAM_BITS),
         .OFFSET_BINARY (OFFSET_BINARY),
         .WIN           (WIN),
         .HOLDOFF       (HOLDOFF),
         .POW_BITS      (POW_BITS)
      ) u_pipe (
         .aclk      (aclk),
         .aresetn   (aresetn),
         .samp_i    (beam_i[beam_lsb(b, 0, NSAMP, BEAM_BITS) +: NSAMP*BEAM_BITS]),
         .mask_i    (beam_mask_i[b]),
         .thr_i     (thr_act_q[b]),
         .trigger_o (trig[b])
      );
   end

   // Active takes the pre-edge staging values, so a write on the update edge
   // only lands in staging.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int b = 0; b < NBEAMS; b++) begin
            thr_stage_q[b] <= '1;
            thr_act_q[b]   <= '1;
         end
      end else begin
         if (thr_update_i)
            for (int b = 0; b < NBEAMS; b++) thr_act_q[b] <= thr_stage_q[b];
         if (thr_wr_i && ({1'b0, thr_addr_i} < NB_L))
            thr_stage_q[thr_addr_i] <= thr_dat_i;
      end
   end

   assign per_last = (per_q == PER_W'(PERIOD_CLKS - 1));

   always_comb begin
      rd_run  = '0;
      rd_lat  = '0;
      rd_trig = 1'b0;
      if ({1'b0, count_addr_i} < NB_L) begin
         rd_run  = run_q[count_addr_i];
         rd_lat  = lat_q[count_addr_i];
         rd_trig = trig[count_addr_i];
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         per_q   <= '0;
         done_q  <= 1'b0;
         count_q <= '0;
         for (int b = 0; b < NBEAMS; b++) begin
            run_q[b] <= '0;
            lat_q[b] <= '0;
         end
      end else begin
         per_q  <= per_last ? '0 : per_q + PER_W'(1);
         done_q <= per_last;
         for (int b = 0; b < NBEAMS; b++) begin
            if (per_last) begin
               lat_q[b] <= cnt_inc(run_q[b], trig[b]);
               run_q[b] <= '0;
            end else begin
               run_q[b] <= cnt_inc(run_q[b], trig[b]);
            end
         end
         // Bypass on the closing edge so count_o is fresh together with count_done_o.
         count_q <= per_last ? cnt_inc(rd_run, rd_trig) : rd_lat;
      end
   end

   assign trigger_o    = trig;
   assign count_o      = count_q;
   assign count_done_o = done_q;

endmodule

// File: tb/tb_beam_power_trigger.sv
module tb_beam_power_trigger;

   localparam int NB  = 6;
   localparam int NS  = 8;
   localparam int BB  = 8;
   localparam int CW  = 4;
   localparam int PER = 1000;
   localparam int PW  = 20;
   localparam int AW  = 3;

   logic                  aclk = 1'b0;
   logic                  aresetn = 1'b0;
   logic [NB*NS*BB-1:0]   beam, beam_ob;
   logic [NB-1:0]         mask;
   logic                  thr_wr, thr_update;
   logic [AW-1:0]         thr_addr, count_addr;
   logic [PW-1:0]         thr_dat;
   logic [NB-1:0]         trig_m, trig_o;
   logic [CW-1:0]         cnt_m, cnt_ob;
   logic                  done_m, done_ob;

   always #5 aclk = ~aclk;

   beam_power_trigger #(
      .NBEAMS(NB), .NSAMP(NS), .BEAM_BITS(BB), .OFFSET_BINARY("FALSE"), .WIN(4),
      .HOLDOFF(8), .CNT_BITS(CW), .PERIOD_CLKS(PER)
   ) u_dut (
      .aclk(aclk), .aresetn(aresetn), .beam_i(beam), .beam_mask_i(mask),
      .thr_wr_i(thr_wr), .thr_addr_i(thr_addr), .thr_dat_i(thr_dat),
      .thr_update_i(thr_update), .trigger_o(trig_m), .count_addr_i(count_addr),
      .count_o(cnt_m), .count_done_o(done_m)
   );

   // Offset-binary instance fed the same samples re-encoded, so it must match.
   beam_power_trigger #(
      .NBEAMS(NB), .NSAMP(NS), .BEAM_BITS(BB), .OFFSET_BINARY("TRUE"), .WIN(4),
      .HOLDOFF(8), .CNT_BITS(CW), .PERIOD_CLKS(PER)
   ) u_dut_ob (
      .aclk(aclk), .aresetn(aresetn), .beam_i(beam_ob), .beam_mask_i(mask),
      .thr_wr_i(thr_wr), .thr_addr_i(thr_addr), .thr_dat_i(thr_dat),
      .thr_update_i(thr_update), .trigger_o(trig_o), .count_addr_i(count_addr),
      .count_o(cnt_ob), .count_done_o(done_ob)
   );

   typedef struct {
      logic [7:0] val;
      int         thr;
      int         exp;
   } vec_t;

   vec_t vecs [11];

   int tests = 0, fails = 0, cyc = 0, k, e;
   int pcnt_m [NB], pfirst_m [NB], plast_m [NB], pcnt_o [NB];
   int done_cnt, done_first, done_last, done_ob_cnt;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic clear_stats();
      for (int b = 0; b < NB; b++) begin
         pcnt_m[b] = 0; pfirst_m[b] = -1; plast_m[b] = -1; pcnt_o[b] = 0;
      end
      done_cnt = 0; done_first = -1; done_last = -1; done_ob_cnt = 0;
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
      cyc++;
      for (int b = 0; b < NB; b++) begin
         if (trig_m[b]) begin
            if (pcnt_m[b] == 0) pfirst_m[b] = cyc;
            plast_m[b] = cyc;
            pcnt_m[b]++;
         end
         if (trig_o[b]) pcnt_o[b]++;
      end
      if (done_m) begin
         if (done_cnt == 0) done_first = cyc;
         done_last = cyc;
         done_cnt++;
      end
      if (done_ob) done_ob_cnt++;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic set_beam(input int b, input logic [7:0] v);
      for (int s = 0; s < NS; s++) begin
         beam[(b*NS+s)*BB +: BB]    = v;
         beam_ob[(b*NS+s)*BB +: BB] = v ^ 8'h80;
      end
   endtask

   task automatic wr_thr(input int a, input int v, input logic upd);
      thr_wr = 1'b1; thr_addr = AW'(a); thr_dat = PW'(v); thr_update = upd;
      tick();
      thr_wr = 1'b0; thr_update = 1'b0;
   endtask

   task automatic do_update();
      thr_update = 1'b1;
      tick();
      thr_update = 1'b0;
   endtask

   task automatic pulse(input int b, input logic [7:0] v);
      set_beam(b, v);
      tick();
      k = cyc;
      set_beam(b, 8'h00);
      ticks(16);
   endtask

   task automatic do_reset();
      for (int b = 0; b < NB; b++) set_beam(b, 8'h00);
      mask = '0; thr_wr = 1'b0; thr_update = 1'b0; thr_addr = '0; thr_dat = '0; count_addr = '0;
      @(negedge aclk);
      aresetn = 1'b0;
      repeat (3) @(negedge aclk);
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
      cyc = 0;
      clear_stats();
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{8'h0A, 799,    1};
      vecs[1]  = '{8'h0A, 800,    0};
      vecs[2]  = '{8'hF6, 799,    1};
      vecs[3]  = '{8'h01, 7,      1};
      vecs[4]  = '{8'h01, 8,      0};
      vecs[5]  = '{8'h7F, 129031, 1};
      vecs[6]  = '{8'h7F, 129032, 0};
      vecs[7]  = '{8'h80, 131071, 1};
      vecs[8]  = '{8'h80, 131072, 0};
      vecs[9]  = '{8'h00, 0,      0};
      vecs[10] = '{8'h05, 199,    1};

      // Reset state and idle behaviour
      do_reset();
      check("rst trigger", int'(trig_m), 0);
      check("rst count", int'(cnt_m), 0);
      check("rst done", int'(done_m), 0);
      ticks(2000);
      check("idle trig main", pcnt_m[0]+pcnt_m[1]+pcnt_m[2]+pcnt_m[3]+pcnt_m[4]+pcnt_m[5], 0);
      check("idle trig ob", pcnt_o[0]+pcnt_o[1]+pcnt_o[2]+pcnt_o[3]+pcnt_o[4]+pcnt_o[5], 0);
      check("done pulses", done_cnt, 2);
      check("done first", done_first, 1000);
      check("done last", done_last, 2000);
      check("done pulses ob", done_ob_cnt, 2);
      for (int a = 0; a < NB; a++) begin
         count_addr = AW'(a);
         tick();
         check($sformatf("idle count %0d", a), int'(cnt_m), 0);
         check($sformatf("idle count ob %0d", a), int'(cnt_ob), 0);
      end

      // Single-clock pulses on beam 0 against a range of thresholds
      for (int i = 0; i < 11; i++) begin
         wr_thr(0, vecs[i].thr, 1'b0);
         do_update();
         clear_stats();
         pulse(0, vecs[i].val);
         check($sformatf("vec%0d pulses", i), pcnt_m[0], vecs[i].exp);
         check($sformatf("vec%0d edge", i), pfirst_m[0], (vecs[i].exp != 0) ? k+3 : -1);
         check($sformatf("vec%0d ob pulses", i), pcnt_o[0], vecs[i].exp);
      end

      // Full-scale negative input held: acc peaks at 524288
      wr_thr(0, 524287, 1'b0);
      do_update();
      clear_stats();
      set_beam(0, 8'h80);
      tick();
      k = cyc;
      ticks(29);
      set_beam(0, 8'h00);
      ticks(20);
      check("full count", pcnt_m[0], 3);
      check("full first", pfirst_m[0], k+6);
      check("full last", plast_m[0], k+24);
      check("full ob count", pcnt_o[0], 3);
      wr_thr(0, 524288, 1'b0);
      do_update();
      clear_stats();
      set_beam(0, 8'h80);
      ticks(30);
      set_beam(0, 8'h00);
      ticks(20);
      check("full at thr", pcnt_m[0], 0);

      // Double-buffered thresholds on beam 2
      wr_thr(2, 100, 1'b0);
      clear_stats();
      pulse(2, 8'h0A);
      check("dbuf staged only", pcnt_m[2], 0);
      do_update();
      clear_stats();
      pulse(2, 8'h0A);
      check("dbuf updated", pcnt_m[2], 1);
      wr_thr(2, 50, 1'b1);
      clear_stats();
      pulse(2, 8'h03);
      check("dbuf wr+upd", pcnt_m[2], 0);
      do_update();
      clear_stats();
      pulse(2, 8'h03);
      check("dbuf staged 50", pcnt_m[2], 1);
      wr_thr(2, 4000, 1'b0);
      do_update();
      clear_stats();
      set_beam(2, 8'h0A);
      ticks(10);
      check("dbuf below", pcnt_m[2], 0);
      wr_thr(2, 100, 1'b0);
      thr_update = 1'b1;
      tick();
      e = cyc;
      thr_update = 1'b0;
      ticks(5);
      check("dbuf update edge", pfirst_m[2], e+1);
      check("dbuf update count", pcnt_m[2], 1);
      set_beam(2, 8'h00);
      ticks(20);

      // Reset in the middle of activity, then one scaler period
      wr_thr(0, 0, 1'b0);
      do_update();
      set_beam(0, 8'h7F);
      ticks(10);
      do_reset();
      mask = 6'b010000;
      wr_thr(0, 0, 1'b0);
      wr_thr(1, 799, 1'b0);
      wr_thr(3, 0, 1'b0);
      wr_thr(4, 799, 1'b0);
      wr_thr(5, 799, 1'b0);
      do_update();
      ticks(3);
      set_beam(3, 8'h0A); set_beam(4, 8'h0A); set_beam(5, 8'h0A);
      ticks(30);
      set_beam(4, 8'h00); set_beam(5, 8'h00);
      ticks(300 - cyc);
      set_beam(3, 8'h00);
      ticks(995 - cyc);
      set_beam(1, 8'h0A);
      tick();
      set_beam(1, 8'h00);
      count_addr = 3'd5;
      ticks(4);
      check("post-reset beam0", pcnt_m[0], 0);
      check("beam5 pulses", pcnt_m[5], 4);
      check("beam5 first", pfirst_m[5], 13);
      check("beam5 last", plast_m[5], 40);
      check("masked pulses", pcnt_m[4], 0);
      check("last-clock trig edge", plast_m[1], 999);
      check("period done", int'(done_m), 1);
      check("count beam5", int'(cnt_m), 4);
      check("count beam5 ob", int'(cnt_ob), 4);
      count_addr = 3'd4;
      tick();
      check("count masked", int'(cnt_m), 0);
      count_addr = 3'd3;
      tick();
      check("count saturated", int'(cnt_m), 15);
      count_addr = 3'd1;
      tick();
      check("count last-clock", int'(cnt_m), 1);
      count_addr = 3'd0;
      tick();
      check("count beam0", int'(cnt_m), 0);
      ticks(1999 - cyc);
      count_addr = 3'd1;
      tick();
      check("period2 done", int'(done_m), 1);
      check("period2 beam1", int'(cnt_m), 0);
      count_addr = 3'd3;
      tick();
      check("period2 beam3", int'(cnt_m), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/beam_power_trigger.md
# beam_power_trigger

Parametrised beam-power trigger stage for the L1 path. It takes pre-formed beam sums, several samples per clock per beam, and computes per-clock power as a sum of squares. It integrates that power over a sliding window and compares it against a double-buffered per-beam threshold, with per-beam holdoff and masking. It also keeps per-beam trigger scalers over a fixed period. Compared with the current L1 trigger, it generalises beam count, samples per clock, sample width, window depth and input encoding.

## Interface
- NBEAMS, 48: number of beams.
- NSAMP, 8: samples per clock per beam (power of 2).
- BEAM_BITS, 8: beam-sum sample width.
- OFFSET_BINARY, "FALSE": "TRUE" means inputs are offset binary and the MSB is inverted on entry.
- WIN, 4: sliding-window depth in clocks (power of 2).
- HOLDOFF, 8: clocks of trigger suppression after a trigger.
- CNT_BITS, 16: scaler width.
- PERIOD_CLKS, 375000: scaler period in clocks.
- Derived: POW_BITS = 2*BEAM_BITS-1 + clog2(NSAMP) + clog2(WIN), which is 20 at the defaults.
- aclk  in  1  sole clock.
- aresetn  in  1  reset, asynchronous, active-low.
- beam_i  in  NBEAMS*NSAMP*BEAM_BITS  beam b, sample s at bits [(b*NSAMP+s)*BEAM_BITS +: BEAM_BITS]; sampled every clock.
- beam_mask_i  in  NBEAMS  1 = beam masked.
- thr_wr_i  in  1  write strobe into the staging threshold.
- thr_addr_i  in  clog2(NBEAMS)  beam index.
- thr_dat_i  in  POW_BITS  threshold value.
- thr_update_i  in  1  copy all staging thresholds into the active thresholds.
- trigger_o  out  NBEAMS  per-beam trigger pulse.
- count_addr_i  in  clog2(NBEAMS)  scaler readout index.
- count_o  out  CNT_BITS  latched scaler for count_addr_i.
- count_done_o  out  1  one-clock pulse when the latched scalers update.

## Operation
- Input decode: in offset-binary mode the MSB is inverted; the sample is then treated as signed.
- Stage 1: each sample is squared, unsigned, 2*BEAM_BITS-1 bits; (-2^(BEAM_BITS-1))^2 must fit.
- Stage 2: the NSAMP squares of a beam are summed.
- Stage 3: a WIN-deep shift register holds the stage-2 sums; acc <= acc + newest - oldest. No overflow is possible at POW_BITS.
- Stage 4: the beam fires when acc > active threshold (strict), the beam is unmasked, and its holdoff counter is 0.
- Holdoff: a trigger loads the counter with HOLDOFF; the counter decrements each clock. Triggers are spaced at least HOLDOFF+1 clocks apart.
- Thresholds:
  - thr_wr_i writes staging[thr_addr_i].
  - thr_update_i copies staging to active on the same edge.
  - Simultaneous write and update: active receives the old staging values; the write lands in staging only.
  - Out-of-range addresses are ignored.
- Masking: a masked beam neither triggers nor counts. Its pipeline keeps running, so unmasking uses a valid window immediately.
- Scalers:
  - The period counter runs 0..PERIOD_CLKS-1.
  - Running per-beam counts increment on trigger_o and saturate at all-ones.
  - On the period's last clock: latched = running + this clock's trigger (saturating), running is cleared, and count_done_o pulses.
- Reset (aresetn low):
  - Staging and active thresholds = all-ones.
  - Window, accumulators, holdoff, scalers and period counter = 0.
  - trigger_o = 0, count_o = 0, count_done_o = 0.
- Reset mid-operation: the window empties, and triggers and scalers restart from zero.

## Timing
- Latency: 4 register stages. Data captured at edge k produces trigger_o registered at edge k+3.
- Window: a single nonzero clock of input keeps acc elevated for exactly WIN clocks.
- Threshold update takes effect on the comparison at the edge after thr_update_i is sampled.
- count_o is registered, with one clock of latency from count_addr_i.
- count_done_o is high for one clock; the new values are valid on count_o from that same clock.

## Structure
- Package beam_trig_pkg holds:
  - the POW_BITS function;
  - the beam-slice indexing function;
  - the saturating-increment function.
- Sub-module beam_power_pipe: one beam's decode/square/sum/window/compare/holdoff. The top level generates NBEAMS instances and owns the threshold banks, scalers and period counter.

## Test plan
- Reset with zero input, PERIOD_CLKS=1000:
  - trigger_o=0 throughout.
  - count_done_o pulses every 1000 clocks.
  - All count_o=0.
- Beam 0, all samples 10, for one clock:
  - acc=800 for 4 clocks.
  - Threshold 799 → single trigger_o[0] pulse at edge k+3.
  - Threshold 800 → none.
- All samples -128, held:
  - Per-clock power 131072, acc saturates at 524288 with no wrap.
  - Threshold 524287 → fires.
- Beam 5 above threshold for 30 clocks, HOLDOFF=8:
  - Pulses at t, t+9, t+18, t+27.
  - Latched count=4.
- Double buffer:
  - Write 100 without update → unchanged.
  - Update → new threshold on the next edge.
  - Write 50 together with update → active=100, staging=50.
- Other modes:
  - Masked beam never fires or counts.
  - CNT_BITS=4 saturates at 15.
  - A trigger on the period's last clock counts in the closing period.
  - OFFSET_BINARY="TRUE": input 0x80 gives power 0; input 0x8A behaves as 10.
